guess_entry_ctrl: RTL and testbench

Keystroke-driven controller that sequences the 40-bit guess register (five 8-bit letters) in the wordle processor datapath. It accepts one key code per handshake, writes letters into successive byte slots, and handles backspace and enter. On a full-word enter it presents the packed guess to the processor core and clears the register once the core accepts it.

---
 rtl/guess_defs.sv | 20 ++
 rtl/key_decode.sv | 28 ++
 rtl/guess_entry_ctrl.sv | 102 ++++++++++
 tb/tb_guess_entry_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/guess_defs.sv
// Shared key codes, state encoding and size defaults for the guess entry controller.
package guess_defs;
   localparam int LETTERS_DEF = 5;
   localparam int CHAR_W_DEF  = 8;

   localparam logic [7:0] KEY_BS      = 8'h08;
   localparam logic [7:0] KEY_ENTER   = 8'h0D;
   localparam logic [7:0] KEY_A       = 8'h41;
   localparam logic [7:0] KEY_Z       = 8'h5A;
   localparam logic [7:0] KEY_LC_A    = 8'h61;
   localparam logic [7:0] KEY_LC_Z    = 8'h7A;
   localparam logic [7:0] CASE_OFFSET = 8'h20;

   typedef enum logic [1:0] {
      ST_EDIT   = 2'd0,
      ST_FULL   = 2'd1,
      ST_SUBMIT = 2'd2,
      ST_CLEAR  = 2'd3
   } state_e;
endpackage

// File: rtl/key_decode.sv
// Combinational key classifier; GUESS_CASE_FOLD_EN folds lowercase letters to uppercase.
module key_decode
   import guess_defs::*;
#(
   parameter int CHAR_W = CHAR_W_DEF
) (
   input  logic [CHAR_W-1:0] i_key_code,
   output logic              o_is_letter,
   output logic              o_is_bs,
   output logic              o_is_enter,
   output logic [CHAR_W-1:0] o_letter_out
);
   logic w_upper;

   assign w_upper    = (i_key_code >= CHAR_W'(KEY_A)) && (i_key_code <= CHAR_W'(KEY_Z));
   assign o_is_bs    = (i_key_code == CHAR_W'(KEY_BS));
   assign o_is_enter = (i_key_code == CHAR_W'(KEY_ENTER));

`ifdef GUESS_CASE_FOLD_EN
   logic w_lower;
   assign w_lower      = (i_key_code >= CHAR_W'(KEY_LC_A)) && (i_key_code <= CHAR_W'(KEY_LC_Z));
   assign o_is_letter  = w_upper || w_lower;
   assign o_letter_out = w_lower ? (i_key_code - CHAR_W'(CASE_OFFSET)) : i_key_code;
`else
   assign o_is_letter  = w_upper;
   assign o_letter_out = i_key_code;
`endif
endmodule

// File: rtl/guess_entry_ctrl.sv
// Keystroke sequencer for the external guess register (build option: GUESS_CASE_FOLD_EN).
module guess_entry_ctrl
   import guess_defs::*;
#(
   parameter  int LETTERS = LETTERS_DEF,
   parameter  int CHAR_W  = CHAR_W_DEF,
   localparam int GW      = LETTERS * CHAR_W
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              key_valid,
   output logic              key_ready,
   input  logic [CHAR_W-1:0] key_code,
   output logic              reg_ie,
   output logic [GW-1:0]     reg_indata,
   input  logic [GW-1:0]     reg_q,
   output logic              guess_valid,
   input  logic              guess_ready,
   output logic [GW-1:0]     guess_data,
   output logic [2:0]        count,
   output logic              err
);
   state_e            r_state;
   logic [2:0]        r_count;
   logic              r_err;
   logic              w_is_letter;
   logic              w_is_bs;
   logic              w_is_enter;
   logic [CHAR_W-1:0] w_letter;
   logic              w_accept;
   logic              w_put_letter;
   logic              w_backspace;

   key_decode #(.CHAR_W(CHAR_W)) u_key_decode (
      .i_key_code   (key_code),
      .o_is_letter  (w_is_letter),
      .o_is_bs      (w_is_bs),
      .o_is_enter   (w_is_enter),
      .o_letter_out (w_letter)
   );

   // clr gates the handshakes combinationally so they drop in the cycle clr is raised
   assign key_ready    = !clr && ((r_state == ST_EDIT) || (r_state == ST_FULL));
   assign guess_valid  = !clr && (r_state == ST_SUBMIT);
   assign guess_data   = reg_q;
   assign count        = r_count;
   assign err          = r_err;
   assign w_accept     = key_valid && key_ready;
   assign w_put_letter = w_accept && w_is_letter && (r_state == ST_EDIT);
   assign w_backspace  = w_accept && w_is_bs && (r_count != 3'd0);

   always_comb begin
      reg_ie     = 1'b0;
      reg_indata = reg_q;
      if (clr || (r_state == ST_CLEAR)) begin
         reg_ie     = 1'b1;
         reg_indata = '0;
      end else if (w_put_letter) begin
         reg_ie = 1'b1;
         for (int k = 0; k < LETTERS; k++) begin
            if (r_count == 3'(k)) reg_indata[GW-1-CHAR_W*k -: CHAR_W] = w_letter;
         end
      end else if (w_backspace) begin
         reg_ie = 1'b1;
         for (int k = 0; k < LETTERS; k++) begin
            if (r_count == 3'(k + 1)) reg_indata[GW-1-CHAR_W*k -: CHAR_W] = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_state <= ST_EDIT;
         r_count <= 3'd0;
         r_err   <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            ST_EDIT, ST_FULL: begin
               if (w_put_letter) begin
                  r_count <= r_count + 3'd1;
                  if (r_count == 3'(LETTERS - 1)) r_state <= ST_FULL;
               end else if (w_backspace) begin
                  r_count <= r_count - 3'd1;
                  r_state <= ST_EDIT;
               end else if (w_accept && w_is_enter && (r_state == ST_FULL)) begin
                  r_state <= ST_SUBMIT;
               end else if (w_accept) begin
                  r_err <= 1'b1;
               end
            end
            ST_SUBMIT: begin
               if (guess_ready) r_state <= ST_CLEAR;
            end
            ST_CLEAR: begin
               r_count <= 3'd0;
               r_state <= ST_EDIT;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_guess_entry_ctrl.sv
// Directed bench for guess_entry_ctrl with a behavioural 40-bit guess register.
module tb_guess_entry_ctrl;
   logic        clk = 1'b0;
   logic        clr;
   logic        key_valid;
   logic        key_ready;
   logic [7:0]  key_code;
   logic        reg_ie;
   logic [39:0] reg_indata;
   logic [39:0] reg_q;
   logic        guess_valid;
   logic        guess_ready;
   logic [39:0] guess_data;
   logic [2:0]  count;
   logic        err;

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {
      logic        kv;
      logic [7:0]  code;
      logic        gr;
      logic [39:0] q;
      logic [2:0]  cnt;
      logic        er;
      logic        kr;
      logic        gv;
   } vec_t;

   vec_t vecs[$];

   guess_entry_ctrl dut (
      .clk         (clk),
      .clr         (clr),
      .key_valid   (key_valid),
      .key_ready   (key_ready),
      .key_code    (key_code),
      .reg_ie      (reg_ie),
      .reg_indata  (reg_indata),
      .reg_q       (reg_q),
      .guess_valid (guess_valid),
      .guess_ready (guess_ready),
      .guess_data  (guess_data),
      .count       (count),
      .err         (err)
   );

   always #5 clk = ~clk;

   // register40 stand-in: write-enabled, never reset except by write
   always @(posedge clk) if (reg_ie) reg_q <= reg_indata;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic kv, input logic [7:0] code, input logic gr,
                      input logic [39:0] q, input logic [2:0] cnt, input logic er,
                      input logic kr, input logic gv);
      vec_t v;
      v.kv = kv; v.code = code; v.gr = gr; v.q = q; v.cnt = cnt;
      v.er = er; v.kr = kr; v.gv = gv;
      vecs.push_back(v);
   endtask

   task automatic key(input logic [7:0] code);
      key_valid = 1'b1;
      key_code  = code;
      tick();
      key_valid = 1'b0;
   endtask

   task automatic state_chk(input string nm, input logic [39:0] q, input logic [2:0] cnt,
                            input logic kr, input logic gv);
      chk({nm, ".q"}, 64'(reg_q), 64'(q));
      chk({nm, ".cnt"}, 64'(count), 64'(cnt));
      chk({nm, ".kr"}, 64'(key_ready), 64'(kr));
      chk({nm, ".gv"}, 64'(guess_valid), 64'(gv));
   endtask

   initial begin
      clr = 1'b1; key_valid = 1'b0; key_code = 8'h00; guess_ready = 1'b0;
      #1;
      chk("rst.kr", 64'(key_ready), 64'd0);
      chk("rst.gv", 64'(guess_valid), 64'd0);
      chk("rst.ie", 64'(reg_ie), 64'd1);
      chk("rst.indata", 64'(reg_indata), 64'd0);
      tick();
      tick();
      clr = 1'b0;
      #1;
      state_chk("rst", 40'h0, 3'd0, 1'b1, 1'b0);
      chk("rst.err", 64'(err), 64'd0);

      // CRANE + enter with guess_ready already high
      add(1, 8'h43, 0, 40'h4300000000, 1, 0, 1, 0);
      add(1, 8'h52, 0, 40'h4352000000, 2, 0, 1, 0);
      add(1, 8'h41, 0, 40'h4352410000, 3, 0, 1, 0);
      add(1, 8'h4E, 0, 40'h4352414E00, 4, 0, 1, 0);
      add(1, 8'h45, 0, 40'h4352414E45, 5, 0, 1, 0);
      add(1, 8'h58, 0, 40'h4352414E45, 5, 1, 1, 0);
      add(1, 8'h0D, 1, 40'h4352414E45, 5, 0, 0, 1);
      add(0, 8'h00, 1, 40'h4352414E45, 5, 0, 0, 0);
      add(0, 8'h00, 0, 40'h0000000000, 0, 0, 1, 0);
      // CRA, enter rejected, backspace, T, then drain to empty
      add(1, 8'h43, 0, 40'h4300000000, 1, 0, 1, 0);
      add(1, 8'h52, 0, 40'h4352000000, 2, 0, 1, 0);
      add(1, 8'h41, 0, 40'h4352410000, 3, 0, 1, 0);
      add(1, 8'h0D, 0, 40'h4352410000, 3, 1, 1, 0);
      add(1, 8'h08, 0, 40'h4352000000, 2, 0, 1, 0);
      add(1, 8'h54, 0, 40'h4352540000, 3, 0, 1, 0);
      add(1, 8'h08, 0, 40'h4352000000, 2, 0, 1, 0);
      add(1, 8'h08, 0, 40'h4300000000, 1, 0, 1, 0);
      add(1, 8'h08, 0, 40'h0000000000, 0, 0, 1, 0);
      add(1, 8'h08, 0, 40'h0000000000, 0, 1, 1, 0);
      add(1, 8'h31, 0, 40'h0000000000, 0, 1, 1, 0);
      add(0, 8'h41, 0, 40'h0000000000, 0, 0, 1, 0);
`ifdef GUESS_CASE_FOLD_EN
      add(1, 8'h63, 0, 40'h4300000000, 1, 0, 1, 0);
`else
      add(1, 8'h63, 0, 40'h0000000000, 0, 1, 1, 0);
`endif

      for (int i = 0; i < vecs.size(); i++) begin
         key_valid   = vecs[i].kv;
         key_code    = vecs[i].code;
         guess_ready = vecs[i].gr;
         tick();
         chk($sformatf("v%0d.q", i), 64'(reg_q), 64'(vecs[i].q));
         chk($sformatf("v%0d.gd", i), 64'(guess_data), 64'(vecs[i].q));
         chk($sformatf("v%0d.cnt", i), 64'(count), 64'(vecs[i].cnt));
         chk($sformatf("v%0d.err", i), 64'(err), 64'(vecs[i].er));
         chk($sformatf("v%0d.kr", i), 64'(key_ready), 64'(vecs[i].kr));
         chk($sformatf("v%0d.gv", i), 64'(guess_valid), 64'(vecs[i].gv));
      end
      key_valid = 1'b0; guess_ready = 1'b0;

      // clr mid-typing
      clr = 1'b1;
      tick();
      clr = 1'b0;
      key(8'h50);
      key(8'h4C);
      state_chk("mid", 40'h504C000000, 3'd2, 1'b1, 1'b0);
      clr = 1'b1;
      #1;
      chk("midclr.kr", 64'(key_ready), 64'd0);
      chk("midclr.ie", 64'(reg_ie), 64'd1);
      chk("midclr.indata", 64'(reg_indata), 64'd0);
      tick();
      clr = 1'b0;
      #1;
      state_chk("midclr", 40'h0, 3'd0, 1'b1, 1'b0);

      // WORDS held in SUBMIT while keys keep arriving
      key(8'h57); key(8'h4F); key(8'h52); key(8'h44); key(8'h53);
      key(8'h0D);
      state_chk("sub", 40'h574F524453, 3'd5, 1'b0, 1'b1);
      key_valid = 1'b1;
      key_code  = 8'h41;
      for (int c = 0; c < 4; c++) begin
         tick();
         state_chk($sformatf("hold%0d", c), 40'h574F524453, 3'd5, 1'b0, 1'b1);
         chk($sformatf("hold%0d.gd", c), 64'(guess_data), 64'h574F524453);
      end
      guess_ready = 1'b1;
      tick();
      guess_ready = 1'b0;
      state_chk("clr1", 40'h574F524453, 3'd5, 1'b0, 1'b0);
      key_valid = 1'b0;
      tick();
      state_chk("clr2", 40'h0, 3'd0, 1'b1, 1'b0);

      // backspace from FULL, refill, then clr mid-SUBMIT
      key(8'h41); key(8'h42); key(8'h43); key(8'h44); key(8'h45);
      key(8'h08);
      state_chk("fullbs", 40'h4142434400, 3'd4, 1'b1, 1'b0);
      key(8'h46);
      state_chk("refill", 40'h4142434446, 3'd5, 1'b1, 1'b0);
      key(8'h0D);
      state_chk("sub2", 40'h4142434446, 3'd5, 1'b0, 1'b1);
      clr = 1'b1;
      #1;
      chk("subclr.gv", 64'(guess_valid), 64'd0);
      tick();
      clr = 1'b0;
      #1;
      state_chk("subclr", 40'h0, 3'd0, 1'b1, 1'b0);
      chk("subclr.err", 64'(err), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
